// File: rtl/wb_select_stage_if.sv
// Write-back stage bus: upstream beat (sources, destination, load controls)
// and the registered beat presented to the register file.
interface wb_select_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        wd_sel;
    logic [NUM_SRC*XLEN-1:0] wd_inputs;
    logic [4:0]              rd_addr;
    logic                    rd_we;
    logic [1:0]              ld_size;
    logic                    ld_unsigned;
    logic [1:0]              ld_offset;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         wd_output;
    logic [4:0]              rd_addr_q;
    logic                    rd_we_q;

    modport master (
        output in_valid, wd_sel, wd_inputs, rd_addr, rd_we,
               ld_size, ld_unsigned, ld_offset, out_ready,
        input  in_ready, out_valid, wd_output, rd_addr_q, rd_we_q
    );

    modport slave (
        input  in_valid, wd_sel, wd_inputs, rd_addr, rd_we,
               ld_size, ld_unsigned, ld_offset, out_ready,
        output in_ready, out_valid, wd_output, rd_addr_q, rd_we_q
    );
endinterface

// File: rtl/wb_select_stage.sv
// Write-back source selector with load alignment/extension, x0 suppression,
// a one-entry valid/ready pipeline register and a retired-write counter.
module wb_select_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int MEM_SRC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_select_stage_if.slave  bus,
    output logic              sel_err,
    output logic [31:0]       wr_count
);

    logic              sel_ok_s;
    logic              is_mem_s;
    logic [XLEN-1:0]   src_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [XLEN-1:0]   ld_s;
    logic [XLEN-1:0]   data_s;
    logic              we_s;
    logic              accept_s;
    logic              drain_s;

    logic              out_valid_r;
    logic [XLEN-1:0]   wd_output_r;
    logic [4:0]        rd_addr_r;
    logic              rd_we_r;
    logic              sel_err_r;
    logic [31:0]       wr_count_r;

    // Source mux; an out-of-range select yields zero
    always_comb begin
        src_s    = '0;
        sel_ok_s = (32'(bus.wd_sel) < 32'(NUM_SRC));
        is_mem_s = (32'(bus.wd_sel) == 32'(MEM_SRC));
        for (int i = 0; i < NUM_SRC; i++) begin
            src_s = (32'(bus.wd_sel) == 32'(i)) ? bus.wd_inputs[i*XLEN +: XLEN] : src_s;
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        ld_s   = '0;
        byte_s = src_s[{bus.ld_offset, 3'b000} +: 8];
        half_s = src_s[{bus.ld_offset[1], 4'b0000} +: 16];
        case (bus.ld_size)
            2'b00: begin
                if (bus.ld_unsigned) begin
                    ld_s = XLEN'(byte_s);
                end else begin
                    ld_s = XLEN'($signed(byte_s));
                end
            end
            2'b01: begin
                if (bus.ld_unsigned) begin
                    ld_s = XLEN'(half_s);
                end else begin
                    ld_s = XLEN'($signed(half_s));
                end
            end
            default: begin
                if (bus.ld_unsigned) begin
                    ld_s = XLEN'(src_s[31:0]);
                end else begin
                    ld_s = XLEN'($signed(src_s[31:0]));
                end
            end
        endcase
    end

    // Final write data and enable; x0 is never written
    always_comb begin
        data_s = '0;
        we_s   = 1'b0;
        if (bus.rd_addr == 5'd0) begin
            data_s = '0;
            we_s   = 1'b0;
        end else begin
            data_s = is_mem_s ? ld_s : src_s;
            we_s   = bus.rd_we;
        end
    end

    assign accept_s     = bus.in_valid && bus.in_ready;
    assign drain_s      = out_valid_r && bus.out_ready;
    assign bus.in_ready = !out_valid_r || bus.out_ready;

    // Pipeline register, sticky select error and retired-write counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            wd_output_r <= '0;
            rd_addr_r   <= 5'd0;
            rd_we_r     <= 1'b0;
            sel_err_r   <= 1'b0;
            wr_count_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                wd_output_r <= data_s;
                rd_addr_r   <= bus.rd_addr;
                rd_we_r     <= we_s;
            end else if (drain_s) begin
                out_valid_r <= 1'b0;
            end
            if (accept_s && !sel_ok_s) begin
                sel_err_r <= 1'b1;
            end
            // Counts the beat leaving, even when a new one replaces it
            if (drain_s && rd_we_r) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.wd_output = wd_output_r;
    assign bus.rd_addr_q = rd_addr_r;
    assign bus.rd_we_q   = rd_we_r;
    assign sel_err       = sel_err_r;
    assign wr_count      = wr_count_r;

endmodule

// File: tb/tb_wb_select_stage.sv
// Randomised scoreboard bench for wb_select_stage (3 sources, so select 3 is
// out of range), with directed load-extension, x0, stall, error and wrap beats.
module tb_wb_select_stage;
    localparam int XLEN    = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int MEM_SRC = 1;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
        logic            serr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel_err;
    logic [31:0] wr_count;

    exp_t        q[$];
    int          checks;
    int          errors;
    logic [31:0] exp_count;
    bit          serr_acc;
    bit          mon_en;
    bit          rand_ready;
    int          stall_left;

    wb_select_stage_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    wb_select_stage #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .MEM_SRC(MEM_SRC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sel_err  (sel_err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the field by byte/half/word arithmetic, then extend
    function automatic logic [XLEN-1:0] model(input int sel, input logic [NUM_SRC*XLEN-1:0] srcs,
                                              input int rd, input int size, input bit uns, input int off);
        logic [XLEN-1:0] w;
        longint unsigned v;
        int bits;
        int shift;
        if (rd == 0 || sel >= NUM_SRC) return '0;
        w = srcs[sel*XLEN +: XLEN];
        if (sel != MEM_SRC) return w;
        case (size)
            0:       begin bits = 8;  shift = off * 8;         end
            1:       begin bits = 16; shift = (off / 2) * 16;  end
            default: begin bits = 32; shift = 0;               end
        endcase
        v = (longint'(w) >> shift) & ((64'd1 << bits) - 64'd1);
        if (!uns && v[bits-1]) v = v - (64'd1 << bits);
        return v[XLEN-1:0];
    endfunction

    task automatic step_ready();
        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send(input int sel, input logic [NUM_SRC*XLEN-1:0] srcs, input int rd,
                        input bit we, input int size, input bit uns, input int off);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        bus.in_valid    = 1'b1;
        bus.wd_sel      = SEL_W'(sel);
        bus.wd_inputs   = srcs;
        bus.rd_addr     = 5'(rd);
        bus.rd_we       = we;
        bus.ld_size     = 2'(size);
        bus.ld_unsigned = uns;
        bus.ld_offset   = 2'(off);
        step_ready();
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                serr_acc = serr_acc | (sel >= NUM_SRC);
                e.data = model(sel, srcs, rd, size, uns, off);
                e.rd   = 5'(rd);
                e.we   = we && (rd != 0);
                e.serr = serr_acc;
                q.push_back(e);
                break;
            end
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 64'(waited), 64'd0);
                break;
            end
            @(posedge clk); #1;
            step_ready();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.wd_sel    = SEL_W'($urandom_range(0, 3));
            bus.wd_inputs = {$urandom, $urandom, $urandom};
            bus.rd_addr   = 5'($urandom);
            step_ready();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (q.size() == 0) break;
            n++;
            if (n > 100) begin
                chk("drain_timeout", 64'(q.size()), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare the presented beat against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.wd_output), 64'd0);
                end else begin
                    e = q[0];
                    chk("wd_output", 64'(bus.wd_output), 64'(e.data));
                    chk("rd_addr_q", 64'(bus.rd_addr_q), 64'(e.rd));
                    chk("rd_we_q",   64'(bus.rd_we_q),   64'(e.we));
                    chk("sel_err",   64'(sel_err),       64'(e.serr));
                    chk("wr_count",  64'(wr_count),      64'(exp_count));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        if (e.we) exp_count = exp_count + 32'd1;
                    end else begin
                        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_SRC*XLEN-1:0] mem_srcs;
        checks = 0; errors = 0; exp_count = 32'd0; serr_acc = 1'b0;
        mon_en = 1'b0; rand_ready = 1'b0; stall_left = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.wd_sel = 2'd0; bus.wd_inputs = {$urandom, $urandom, $urandom};
        bus.rd_addr = 5'd3; bus.rd_we = 1'b1; bus.ld_size = 2'd0; bus.ld_unsigned = 1'b0;
        bus.ld_offset = 2'd0; bus.out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
            chk("rst_wr_count",  64'(wr_count),      64'd0);
            chk("rst_sel_err",   64'(sel_err),       64'd0);
        end
        chk("rst_wd_output", 64'(bus.wd_output), 64'd0);
        chk("rst_rd_addr_q", 64'(bus.rd_addr_q), 64'd0);
        chk("rst_rd_we_q",   64'(bus.rd_we_q),   64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send(0, {32'h0, 32'h0, 32'h12345678}, 5, 1'b1, 2, 1'b0, 0);
        drain();
        chk("wr_count_after_first", 64'(wr_count), 64'd1);

        mem_srcs = {32'hA5A5A5A5, 32'h80F17F22, 32'h0BADF00D};
        send(MEM_SRC, mem_srcs, 1, 1'b1, 0, 1'b0, 2);
        send(MEM_SRC, mem_srcs, 2, 1'b1, 0, 1'b1, 2);
        send(MEM_SRC, mem_srcs, 3, 1'b1, 1, 1'b0, 3);
        send(MEM_SRC, mem_srcs, 4, 1'b1, 2, 1'b0, 1);
        send(2,       mem_srcs, 6, 1'b1, 0, 1'b0, 3);
        send(0, {32'h0, 32'h0, 32'hDEADBEEF}, 0, 1'b1, 0, 1'b0, 0);
        drain();
        chk("wr_count_after_x0", 64'(wr_count), 64'd6);

        send(0, {32'h0, 32'h0, 32'hAAAA0001}, 8, 1'b1, 2, 1'b0, 0);
        stall_left = 2;
        send(0, {32'h0, 32'h0, 32'hBBBB0002}, 9, 1'b1, 2, 1'b0, 0);
        send(0, {32'h0, 32'h0, 32'hCCCC0003}, 10, 1'b1, 2, 1'b0, 0);
        drain();
        chk("wr_count_after_abc", 64'(wr_count), 64'd9);
        chk("sel_err_before_err", 64'(sel_err), 64'd0);

        send(3, {$urandom, $urandom, $urandom}, 11, 1'b1, 0, 1'b0, 0);
        drain();
        chk("sel_err_sticky", 64'(sel_err), 64'd1);

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send($urandom_range(0, 3), {$urandom, $urandom, $urandom}, $urandom_range(0, 31),
                 1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        drain();
        chk("wr_count_after_random", 64'(wr_count), 64'(exp_count));

        force dut.wr_count_r = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_r;
        exp_count = 32'hFFFFFFFF;
        send(0, {32'h0, 32'h0, 32'h00C0FFEE}, 7, 1'b1, 2, 1'b0, 0);
        drain();
        chk("wr_count_wrap", 64'(wr_count), 64'd0);

        stall_left = 10;
        send(0, {32'h0, 32'h0, 32'h55AA55AA}, 12, 1'b1, 2, 1'b0, 0);
        @(posedge clk); #1;
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst_wr_count",  64'(wr_count),      64'd0);
        chk("midrst_sel_err",   64'(sel_err),       64'd0);
        q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised write-back selector feeding the register-file write port. Chooses one of NUM_SRC result sources (ALU, load data, PC+4, immediate, …), byte-aligns and sign/zero-extends load data, suppresses writes to x0, and holds the result in a pipeline register under a valid/ready handshake. Sits between the memory stage and the register file and counts retired writes.

## Interface
Parameters:
- XLEN, 32, datapath width in bits; multiple of 8, at least 32.
- NUM_SRC, 4, number of write-data sources; 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_SRC.
- MEM_SRC, 1, index of the source that receives load alignment and extension.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- wd_sel  in  SEL_W  source select.
- wd_inputs  in  NUM_SRC*XLEN  flattened sources; source i occupies bits [i*XLEN +: XLEN].
- rd_addr  in  5  destination register.
- rd_we  in  1  write request.
- ld_size  in  2  00 byte, 01 half, 10 and 11 word.
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- ld_offset  in  2  byte offset of load address.
- out_valid  out  1  registered beat valid.
- out_ready  in  1  register file accepts the beat.
- wd_output  out  XLEN  registered write data.
- rd_addr_q  out  5  registered destination.
- rd_we_q  out  1  registered write enable.
- sel_err  out  1  sticky; an out-of-range select was accepted.
- wr_count  out  32  retired write counter.

## Operation
- Beat transfer in: in_valid && in_ready. Beat transfer out: out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational), giving one beat per cycle with no bubble.
- Selection: src = wd_inputs[wd_sel].
- If wd_sel >= NUM_SRC, src = 0 and sel_err is set on accept. sel_err clears only on reset.
- Load path, when wd_sel == MEM_SRC:
  - Byte: take byte ld_offset of the source.
  - Half: take halfword ld_offset[1]; ld_offset[0] is ignored.
  - Word: take bits [31:0]; ld_offset is ignored.
  - Extend to XLEN: sign-extend from the top bit of the extracted field when ld_unsigned = 0, zero-extend otherwise.
- All other sources pass through unmodified; ld_size, ld_unsigned and ld_offset are ignored.
- x0 rule: if rd_addr == 0, the captured rd_we_q = 0 and wd_output = 0, regardless of rd_we.
- On accept, capture data, rd_addr, the effective write enable, and set out_valid = 1.
- On a drain with no new accept, clear out_valid. Data registers hold their last value.
- wr_count increments by 1 on each output transfer with rd_we_q = 1. It wraps from 0xFFFFFFFF to 0 and does not saturate.

## Timing
- Latency is 1 cycle from input accept to out_valid.
- Throughput is 1 beat per cycle while out_ready = 1.
- Reset values:
  - out_valid = 0, wd_output = 0, rd_addr_q = 0, rd_we_q = 0.
  - sel_err = 0, wr_count = 0.
  - in_ready = 1 during and after reset, as follows from out_valid = 0.
- Reset asserted mid-operation discards any held beat at the next edge; no output transfer is counted on that edge.
- Stall: out_valid = 1 with out_ready = 0 keeps all outputs stable and holds in_ready = 0. Inputs are ignored.
- Simultaneous drain and accept in one cycle: the new beat replaces the old one, out_valid stays 1, and wr_count counts the drained beat.
- in_valid with in_ready = 0 is not a transfer; upstream must hold the beat.
- wr_count updates on the same edge as the output transfer.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, wr_count = 0, sel_err = 0, in_ready = 1.
- Pass-through: sel = 0, src0 = 0x12345678, rd = 5, we = 1, out_ready = 1 -> next cycle wd_output = 0x12345678, rd_addr_q = 5, rd_we_q = 1; wr_count = 1 after the drain.
- Load extension with mem = 0x80F17F22:
  - Byte, offset 2, signed -> 0xFFFFFFF1.
  - Byte, offset 2, unsigned -> 0x000000F1.
  - Half, offset 3, signed -> 0xFFFF80F1 (offset[0] ignored).
  - Word, offset 1 -> 0x80F17F22.
- x0 suppression: rd = 0, we = 1, src = 0xDEADBEEF -> rd_we_q = 0, wd_output = 0, and wr_count is unchanged after the drain.
- Backpressure: 3 back-to-back beats A, B, C with out_ready = 0 on cycles 2–3 -> A is held stable and in_ready = 0 during the stall; output order is A, B, C with no loss or duplication; wr_count = 3.
- Error and wrap:
  - NUM_SRC = 3 with sel = 3 -> wd_output = 0 and sel_err = 1, and sel_err stays 1.
  - Force wr_count to 0xFFFFFFFF, then drain one write -> wr_count = 0.
